// File: rtl/vanilla_decode_queue.sv
// vanilla_decode_queue: pre-decode instruction queue between fetch and ID with memory-op throttling
module vanilla_decode_queue #(
    parameter int els_p         = 4,
    parameter int pc_width_p    = 22,
    parameter int max_out_p     = 32,
    parameter int count_width_p = 16
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             fetch_v_i,
    input  logic [31:0]                      fetch_instr_i,
    input  logic [pc_width_p-1:0]            fetch_pc_i,
    output logic                             fetch_ready_o,
    input  logic                             flush_i,
    output logic                             issue_v_o,
    output logic [31:0]                      issue_instr_o,
    output logic [pc_width_p-1:0]            issue_pc_o,
    output logic [3:0]                       issue_class_o,
    output logic [4:0]                       issue_rd_o,
    output logic                             issue_write_rd_o,
    input  logic                             issue_yumi_i,
    input  logic                             mem_resp_v_i,
    output logic                             fence_stall_o,
    output logic [$clog2(max_out_p+1)-1:0]   out_cnt_o,
    output logic [count_width_p-1:0]         unsup_cnt_o,
    output logic                             empty_o,
    output logic                             full_o
);
    localparam int aw = $clog2(els_p);
    localparam int ow = $clog2(max_out_p + 1);
    localparam logic [3:0] c_alu = 4'd0, c_load = 4'd1, c_store = 4'd2, c_branch = 4'd3,
                           c_jump = 4'd4, c_fp = 4'd5, c_system = 4'd6, c_fence = 4'd7,
                           c_amo = 4'd8, c_idiv = 4'd9, c_unsup = 4'd10;

    logic [aw:0]             wptr, rptr;
    logic [31:0]             instr_mem [els_p];
    logic [pc_width_p-1:0]   pc_mem [els_p];
    logic [3:0]              cls;
    logic [6:0]              opc, f7;
    logic [2:0]              f3;
    logic                    enq, deq, mem_op, at_max, hold, inc, dec;

    assign empty_o       = wptr == rptr;
    assign full_o        = (wptr[aw-1:0] == rptr[aw-1:0]) && (wptr[aw] != rptr[aw]);
    assign fetch_ready_o = !full_o;
    assign enq           = fetch_v_i && !full_o && !flush_i;
    assign issue_instr_o = instr_mem[rptr[aw-1:0]];
    assign issue_pc_o    = pc_mem[rptr[aw-1:0]];
    assign opc           = issue_instr_o[6:0];
    assign f3            = issue_instr_o[14:12];
    assign f7            = issue_instr_o[31:25];
    assign issue_rd_o    = issue_instr_o[11:7];
    assign issue_class_o = cls;
    assign mem_op        = cls == c_load || cls == c_store || cls == c_amo;
    assign at_max        = out_cnt_o == ow'(max_out_p);
    assign hold          = (cls == c_fence && out_cnt_o != '0) || (mem_op && at_max);
    assign issue_v_o     = !empty_o && !hold;
    assign fence_stall_o = !empty_o && cls == c_fence && out_cnt_o != '0;
    assign deq           = issue_yumi_i && issue_v_o;
    assign inc           = deq && mem_op;
    assign dec           = mem_resp_v_i && (out_cnt_o != '0 || inc);
    assign issue_write_rd_o = issue_rd_o != 5'd0 &&
        (cls == c_alu || cls == c_jump || cls == c_system || cls == c_amo || cls == c_idiv ||
         (cls == c_load && opc == 7'b0000011));

    // classify the head instruction by opcode, splitting the M-extension OP space
    always_comb begin
        cls = c_unsup;
        case (opc)
            7'b0110011: cls = f7 != 7'b0000001 ? c_alu : f3[2] ? c_idiv : f3 == 3'b000 ? c_alu : c_unsup;
            7'b0010011, 7'b0110111, 7'b0010111: cls = c_alu;
            7'b0000011, 7'b0000111: cls = c_load;
            7'b0100011, 7'b0100111: cls = c_store;
            7'b1100011: cls = c_branch;
            7'b1101111, 7'b1100111: cls = c_jump;
            7'b1010011, 7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: cls = c_fp;
            7'b1110011: cls = c_system;
            7'b0001111: cls = c_fence;
            7'b0101111: cls = c_amo;
            default: cls = c_unsup;
        endcase
    end

    // entry storage, deliberately left unreset
    always_ff @(posedge clk_i) begin
        if (enq) begin
            instr_mem[wptr[aw-1:0]] <= fetch_instr_i;
            pc_mem[wptr[aw-1:0]]    <= fetch_pc_i;
        end
    end

    // wrap-bit pointers; flush wins over any same-cycle enqueue or dequeue
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (enq) wptr <= wptr + {{aw{1'b0}}, 1'b1};
            if (deq) rptr <= rptr + {{aw{1'b0}}, 1'b1};
        end
    end

    // outstanding memory ops survive flush since their responses still arrive
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) out_cnt_o <= '0;
        else if (inc && !dec) out_cnt_o <= out_cnt_o + ow'(1);
        else if (dec && !inc) out_cnt_o <= out_cnt_o - ow'(1);
    end

    // saturating count of unsupported instructions handed to ID
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) unsup_cnt_o <= '0;
        else if (deq && cls == c_unsup && !(&unsup_cnt_o)) unsup_cnt_o <= unsup_cnt_o + count_width_p'(1);
    end

    a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i) issue_yumi_i |-> issue_v_o);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(inc && !dec && at_max));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(mem_resp_v_i && !inc && out_cnt_o == '0));
endmodule

// File: tb/tb_vanilla_decode_queue.sv
// tb_vanilla_decode_queue: directed scenario tests for the decode queue
module tb_vanilla_decode_queue;
    localparam logic [31:0] addi = 32'h00000093;
    localparam logic [31:0] lw   = 32'h0000A283;
    localparam logic [31:0] sw   = 32'h0050A023;
    localparam logic [31:0] fnc  = 32'h0FF0000F;
    localparam logic [31:0] mulh = 32'h02B51533;
    localparam logic [31:0] div  = 32'h02B54533;

    logic        clk = 0, reset_n = 0, fetch_v = 0, flush = 0, yumi = 0, mem_resp = 0;
    logic [31:0] fetch_instr = '0;
    logic [21:0] fetch_pc = '0;
    logic        fetch_ready, issue_v, issue_write_rd, fence_stall, empty, full;
    logic [31:0] issue_instr;
    logic [21:0] issue_pc;
    logic [3:0]  issue_class;
    logic [4:0]  issue_rd;
    logic [5:0]  out_cnt;
    logic [15:0] unsup_cnt;
    int checks = 0, errors = 0;

    vanilla_decode_queue dut (
        .clk_i(clk), .reset_n_i(reset_n), .fetch_v_i(fetch_v), .fetch_instr_i(fetch_instr),
        .fetch_pc_i(fetch_pc), .fetch_ready_o(fetch_ready), .flush_i(flush), .issue_v_o(issue_v),
        .issue_instr_o(issue_instr), .issue_pc_o(issue_pc), .issue_class_o(issue_class),
        .issue_rd_o(issue_rd), .issue_write_rd_o(issue_write_rd), .issue_yumi_i(yumi),
        .mem_resp_v_i(mem_resp), .fence_stall_o(fence_stall), .out_cnt_o(out_cnt),
        .unsup_cnt_o(unsup_cnt), .empty_o(empty), .full_o(full)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [21:0] pc);
        fetch_v = 1; fetch_instr = instr; fetch_pc = pc;
        step();
        fetch_v = 0;
    endtask

    task automatic pop();
        yumi = 1;
        step();
        yumi = 0;
    endtask

    task automatic test_reset();
        checks++;
        if ({empty, full, fetch_ready, issue_v, fence_stall} !== 5'b10100) begin
            errors++; $display("FAIL reset_flags got %b exp 10100", {empty, full, fetch_ready, issue_v, fence_stall});
        end
        checks++;
        if ({out_cnt, unsup_cnt} !== 22'd0) begin
            errors++; $display("FAIL reset_counts got out=%0d unsup=%0d exp 0 0", out_cnt, unsup_cnt);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) push(addi, 22'h100 + 22'(4 * i));
        checks++;
        if ({full, fetch_ready, issue_v} !== 3'b101) begin
            errors++; $display("FAIL fill_full got %b exp 101", {full, fetch_ready, issue_v});
        end
        push(addi, 22'h200);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (issue_pc !== 22'h100 + 22'(4 * i) || issue_v !== 1'b1 || issue_class !== 4'd0) begin
                errors++; $display("FAIL drain_%0d got pc=%0h v=%b cls=%0d exp pc=%0h v=1 cls=0",
                    i, issue_pc, issue_v, issue_class, 22'h100 + 22'(4 * i));
            end
            pop();
        end
        checks++;
        if ({empty, issue_v} !== 2'b10) begin
            errors++; $display("FAIL drain_empty got %b exp 10", {empty, issue_v});
        end
        push(addi, 22'h300);
        checks++;
        if (issue_pc !== 22'h300 || {issue_v, full, empty} !== 3'b100) begin
            errors++; $display("FAIL wrap got pc=%0h flags=%b exp pc=300 flags=100", issue_pc, {issue_v, full, empty});
        end
        pop();
    endtask

    task automatic test_fence();
        push(lw, 22'h400);
        push(fnc, 22'h404);
        checks++;
        if (issue_class !== 4'd1 || issue_write_rd !== 1'b1 || issue_rd !== 5'd5) begin
            errors++; $display("FAIL lw_decode got cls=%0d wr=%b rd=%0d exp 1 1 5", issue_class, issue_write_rd, issue_rd);
        end
        pop();
        checks++;
        if (out_cnt !== 6'd1 || {fence_stall, issue_v} !== 2'b10 || issue_class !== 4'd7) begin
            errors++; $display("FAIL fence_hold got out=%0d stall/v=%b cls=%0d exp 1 10 7", out_cnt, {fence_stall, issue_v}, issue_class);
        end
        mem_resp = 1;
        step();
        mem_resp = 0;
        checks++;
        if (out_cnt !== 6'd0 || {fence_stall, issue_v} !== 2'b01) begin
            errors++; $display("FAIL fence_release got out=%0d stall/v=%b exp 0 01", out_cnt, {fence_stall, issue_v});
        end
        pop();
    endtask

    task automatic test_mem_max();
        for (int i = 0; i < 32; i++) begin
            push(sw, 22'h500);
            pop();
        end
        push(sw, 22'h504);
        checks++;
        if (out_cnt !== 6'd32 || issue_v !== 1'b0 || fence_stall !== 1'b0 || issue_class !== 4'd2 || issue_write_rd !== 1'b0) begin
            errors++; $display("FAIL max_hold got out=%0d v=%b stall=%b cls=%0d wr=%b exp 32 0 0 2 0",
                out_cnt, issue_v, fence_stall, issue_class, issue_write_rd);
        end
        mem_resp = 1;
        step();
        checks++;
        if (out_cnt !== 6'd31 || issue_v !== 1'b1) begin
            errors++; $display("FAIL max_release got out=%0d v=%b exp 31 1", out_cnt, issue_v);
        end
        yumi = 1;
        step();
        yumi = 0; mem_resp = 0;
        checks++;
        if (out_cnt !== 6'd31 || empty !== 1'b1) begin
            errors++; $display("FAIL resp_and_yumi got out=%0d empty=%b exp 31 1", out_cnt, empty);
        end
        push(sw, 22'h508);
        pop();
        checks++;
        if (out_cnt !== 6'd32) begin
            errors++; $display("FAIL refill_max got out=%0d exp 32", out_cnt);
        end
        mem_resp = 1;
        for (int i = 0; i < 32; i++) step();
        mem_resp = 0;
        checks++;
        if (out_cnt !== 6'd0) begin
            errors++; $display("FAIL drain_out got out=%0d exp 0", out_cnt);
        end
    endtask

    task automatic test_unsup();
        for (int i = 0; i < 3; i++) push(mulh, 22'h600 + 22'(4 * i));
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (issue_class !== 4'd10 || issue_write_rd !== 1'b0 || issue_v !== 1'b1) begin
                errors++; $display("FAIL mulh_%0d got cls=%0d wr=%b v=%b exp 10 0 1", i, issue_class, issue_write_rd, issue_v);
            end
            pop();
        end
        checks++;
        if (unsup_cnt !== 16'd3) begin
            errors++; $display("FAIL unsup_cnt got %0d exp 3", unsup_cnt);
        end
        push(div, 22'h700);
        checks++;
        if (issue_class !== 4'd9 || issue_write_rd !== 1'b1 || issue_rd !== 5'd10 || issue_instr !== div) begin
            errors++; $display("FAIL div_decode got cls=%0d wr=%b rd=%0d instr=%h exp 9 1 10 %h",
                issue_class, issue_write_rd, issue_rd, issue_instr, div);
        end
        pop();
        checks++;
        if (unsup_cnt !== 16'd3 || out_cnt !== 6'd0) begin
            errors++; $display("FAIL div_counts got unsup=%0d out=%0d exp 3 0", unsup_cnt, out_cnt);
        end
    endtask

    task automatic test_flush();
        push(lw, 22'h800);
        push(addi, 22'h804);
        fetch_v = 1; fetch_instr = addi; fetch_pc = 22'h808; yumi = 1; flush = 1;
        step();
        fetch_v = 0; yumi = 0; flush = 0;
        checks++;
        if ({empty, issue_v, full} !== 3'b100 || out_cnt !== 6'd1) begin
            errors++; $display("FAIL flush got flags=%b out=%0d exp 100 1", {empty, issue_v, full}, out_cnt);
        end
        step();
        checks++;
        if (empty !== 1'b1) begin
            errors++; $display("FAIL flush_drop got empty=%b exp 1", empty);
        end
        mem_resp = 1;
        step();
        mem_resp = 0;
        checks++;
        if (out_cnt !== 6'd0) begin
            errors++; $display("FAIL flush_resp got out=%0d exp 0", out_cnt);
        end
    endtask

    task automatic test_reset_mid();
        push(lw, 22'h900);
        push(lw, 22'h904);
        pop();
        pop();
        for (int i = 0; i < 3; i++) push(addi, 22'h908 + 22'(4 * i));
        checks++;
        if (out_cnt !== 6'd2 || issue_v !== 1'b1) begin
            errors++; $display("FAIL pre_reset got out=%0d v=%b exp 2 1", out_cnt, issue_v);
        end
        #2 reset_n = 0;
        #1;
        checks++;
        if ({empty, issue_v, fetch_ready} !== 3'b101 || out_cnt !== 6'd0 || unsup_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_mid got flags=%b out=%0d unsup=%0d exp 101 0 0",
                {empty, issue_v, fetch_ready}, out_cnt, unsup_cnt);
        end
        step();
        reset_n = 1;
        step();
    endtask

    initial begin
        #12 reset_n = 1;
        step();
        test_reset();
        test_fill();
        test_fence();
        test_mem_max();
        test_unsup();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
